// File: rtl/packet_buffer_arbiter.sv
// rtl/packet_buffer_arbiter.sv - single-port packet buffer arbiter for video, RX write and TX read
//
// Grants at most one RAM access per cycle and returns each read word to its owner.
// Priority video > write > read; every granted read returns exactly RAM_LATENCY+1
// cycles after its request was sampled.
//
// Optional feature macro: PKTBUF_STARVE_GUARD_EN
//   defined   : per-requester starvation counters let write/read beat video after
//               STARVE_LIMIT consecutive denied cycles (write wins a tie)
//   undefined : strict priority, no counters
//
// Ports:
//   clk, rst                   clock, asynchronous active-low reset
//   vid_req/vid_addr           video read request (single cycle)
//   vid_ready/vid_val          video read data pulse / data
//   wr_req/wr_addr/wr_data     RX write request, held until wr_ack
//   wr_ack                     write granted this cycle
//   rd_req/rd_addr             TX read request, held until rd_ack
//   rd_ack                     read granted this cycle
//   rd_valid/rd_data           TX read data pulse / data
//   ram_addr/ram_we/ram_din    registered RAM command
//   ram_dout                   RAM read data
module packet_buffer_arbiter #(
  parameter int RAM_SIZE     = 1024,
  parameter int DATA_LEN     = 12,
  parameter int RAM_LATENCY  = 2,
  parameter int STARVE_LIMIT = 15,
  localparam int AW          = $clog2(RAM_SIZE)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                vid_req,
  input  logic [AW-1:0]       vid_addr,
  output logic                vid_ready,
  output logic [DATA_LEN-1:0] vid_val,
  input  logic                wr_req,
  input  logic [AW-1:0]       wr_addr,
  input  logic [DATA_LEN-1:0] wr_data,
  output logic                wr_ack,
  input  logic                rd_req,
  input  logic [AW-1:0]       rd_addr,
  output logic                rd_ack,
  output logic                rd_valid,
  output logic [DATA_LEN-1:0] rd_data,
  output logic [AW-1:0]       ram_addr,
  output logic                ram_we,
  output logic [DATA_LEN-1:0] ram_din,
  input  logic [DATA_LEN-1:0] ram_dout
);

  typedef enum logic [1:0] {TAG_NONE = 2'd0, TAG_VID = 2'd1, TAG_RD = 2'd2} tag_t;

  logic gnt_vid, gnt_wr, gnt_rd;
  logic wr_starved, rd_starved;
  logic run_q;
  tag_t tag_in;
  tag_t tag_pipe [RAM_LATENCY];

  // Keeps the acks low from reset assertion until the first edge after release,
  // so every output reads 0 through reset and the cycle that follows it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) run_q <= 1'b0;
    else      run_q <= 1'b1;
  end

`ifdef PKTBUF_STARVE_GUARD_EN
  localparam int CW = $clog2(STARVE_LIMIT + 1);

  logic [CW-1:0] wr_cnt, rd_cnt;

  assign wr_starved = (wr_cnt == CW'(STARVE_LIMIT));
  assign rd_starved = (rd_cnt == CW'(STARVE_LIMIT));

  // Counts consecutive denied cycles; saturates at the limit so a requester that
  // loses the tie to write stays eligible next cycle instead of wrapping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_cnt <= '0;
      rd_cnt <= '0;
    end else begin
      if (!wr_req || gnt_wr)  wr_cnt <= '0;
      else if (!wr_starved)   wr_cnt <= wr_cnt + 1'b1;
      if (!rd_req || gnt_rd)  rd_cnt <= '0;
      else if (!rd_starved)   rd_cnt <= rd_cnt + 1'b1;
    end
  end
`else
  // No override without the guard; the limit only matters when it is built in.
  assign wr_starved = 1'b0 & (STARVE_LIMIT != 0);
  assign rd_starved = 1'b0;
`endif

  always_comb begin
    gnt_vid = 1'b0;
    gnt_wr  = 1'b0;
    gnt_rd  = 1'b0;
    if (run_q) begin
      if (wr_req && wr_starved)      gnt_wr  = 1'b1;
      else if (rd_req && rd_starved) gnt_rd  = 1'b1;
      else if (vid_req)              gnt_vid = 1'b1;
      else if (wr_req)               gnt_wr  = 1'b1;
      else if (rd_req)               gnt_rd  = 1'b1;
    end
  end

  assign wr_ack = gnt_wr;
  assign rd_ack = gnt_rd;

  always_comb begin
    tag_in = TAG_NONE;
    if (gnt_vid)     tag_in = TAG_VID;
    else if (gnt_rd) tag_in = TAG_RD;
  end

  // RAM command register: address and data hold on idle cycles, only we drops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ram_addr <= '0;
      ram_we   <= 1'b0;
      ram_din  <= '0;
    end else begin
      ram_we <= gnt_wr;
      if (gnt_wr) begin
        ram_addr <= wr_addr;
        ram_din  <= wr_data;
      end else if (gnt_rd) begin
        ram_addr <= rd_addr;
      end else if (gnt_vid) begin
        ram_addr <= vid_addr;
      end
    end
  end

  // Owner tags ride alongside the RAM latency; the output register below is the
  // final stage, giving RAM_LATENCY+1 cycles from request to data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < RAM_LATENCY; i++) tag_pipe[i] <= TAG_NONE;
    end else begin
      tag_pipe[0] <= tag_in;
      for (int i = 1; i < RAM_LATENCY; i++) tag_pipe[i] <= tag_pipe[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vid_ready <= 1'b0;
      vid_val   <= '0;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
    end else begin
      vid_ready <= (tag_pipe[RAM_LATENCY-1] == TAG_VID);
      rd_valid  <= (tag_pipe[RAM_LATENCY-1] == TAG_RD);
      if (tag_pipe[RAM_LATENCY-1] == TAG_VID) vid_val <= ram_dout;
      if (tag_pipe[RAM_LATENCY-1] == TAG_RD)  rd_data <= ram_dout;
    end
  end

endmodule
